// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and default sizing.
package tt_sweep_pkg;
  localparam int NVARS_DEF  = 5;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/tt_vec_counter.sv
// Vector generator: settle counter plus NVARS-bit vector counter with a sample strobe
// and a last-vector flag.
module tt_vec_counter #(
  parameter int NVARS  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [NVARS-1:0] vec,
  output logic             sample,
  output logic             last
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [SW-1:0] settle;

  assign sample = en && (settle == SW'(SETTLE - 1));
  assign last   = &vec;

  // The vector wraps naturally to 0 after the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec    <= '0;
      settle <= '0;
    end else if (clr) begin
      vec    <= '0;
      settle <= '0;
    end else if (sample) begin
      vec    <= vec + 1'b1;
      settle <= '0;
    end else if (en) begin
      settle <= settle + 1'b1;
    end
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustively drives every input vector to a reference and a candidate function and
// reports mismatch count, lowest failing vector and overall pass.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int NVARS  = NVARS_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ref_out,
  input  logic             cand_out,
  output logic [NVARS-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic [NVARS:0]   mismatch_cnt,
  output logic [NVARS-1:0] first_fail_vec,
  output logic             first_fail_valid,
  output logic             pass
);
  state_t state, state_nxt;
  logic   sample, last, clr, start_acc, mism, sweep_end;
  logic [NVARS:0] cnt_nxt;

  assign start_acc = (state == ST_IDLE) && start;
  assign clr       = start_acc || ((state == ST_SWEEP) && abort);
  // Abort wins over a sample landing on the same edge.
  assign mism      = sample && !abort && (ref_out != cand_out);
  assign sweep_end = sample && last && !abort;
  assign cnt_nxt   = mismatch_cnt + (NVARS+1)'(mism);

  assign busy = (state == ST_SWEEP);
  assign done = (state == ST_DONE);

  tt_vec_counter #(.NVARS(NVARS), .SETTLE(SETTLE)) u_vec (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (state == ST_SWEEP),
    .vec    (vec),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (sweep_end) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (start_acc) begin
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      if (mism) begin
        mismatch_cnt <= cnt_nxt;
        if (!first_fail_valid) begin
          first_fail_vec   <= vec;
          first_fail_valid <= 1'b1;
        end
      end
      // Pass is decided with the final sample included and held until next start.
      if (sweep_end) pass <= (cnt_nxt == '0);
    end
  end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter NVARS, default 5: number of boolean inputs swept; vector width.
REQ-002 Parameter SETTLE, default 1 (legal >=1): clock cycles each vector is held before the outputs are sampled.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a full sweep.
REQ-006 abort  input  1  cancels a running sweep.
REQ-007 ref_out  input  1  output of the reference function (e.g. f) under test.
REQ-008 cand_out  input  1  output of the candidate reduced function (e.g. fk) under test.
REQ-009 vec  output  NVARS  registered input vector driven to both functions; bit NVARS-1 = A, bit 0 = last variable.
REQ-010 busy  output  1  high while in SWEEP.
REQ-011 done  output  1  one-cycle pulse when a complete sweep finishes.
REQ-012 mismatch_cnt  output  NVARS+1  number of vectors with ref_out != cand_out.
REQ-013 first_fail_vec  output  NVARS  lowest vector value that mismatched.
REQ-014 first_fail_valid  output  1  high once any mismatch is recorded.
REQ-015 pass  output  1  high from done until next start iff mismatch_cnt == 0.

Function
REQ-016 FSM states: IDLE, SWEEP, DONE.
- IDLE -> SWEEP on start.
- SWEEP -> IDLE on abort.
- SWEEP -> DONE after the last vector is sampled.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On the edge that accepts start in IDLE, the block SHALL:
- set vec = 0 and the settle counter to 0;
- clear mismatch_cnt, first_fail_vec, first_fail_valid and pass;
- assert busy.
REQ-018 In SWEEP, the block SHALL sample ref_out and cand_out at the edge where the settle counter equals SETTLE-1. At that same edge:
- vec increments;
- the settle counter returns to 0.
REQ-019 On a sampled mismatch, mismatch_cnt SHALL increment by 1. If first_fail_valid is low at that edge:
- first_fail_vec captures the current vec;
- first_fail_valid goes high.
REQ-020 The sample of vec = 2^NVARS-1 SHALL cause the SWEEP -> DONE transition; vec wraps to 0 on that edge.
REQ-021 In DONE, the block SHALL drive done = 1, busy = 0 and pass = (mismatch_cnt == 0); pass is held until the next accepted start.
REQ-022 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k + 2^NVARS*SETTLE.
REQ-023 start SHALL be ignored while in SWEEP or DONE.
REQ-024 abort in SWEEP SHALL return the FSM to IDLE on the next edge with busy = 0, done never asserted, pass = 0 and vec = 0.
- mismatch_cnt and first_fail_* SHALL retain their partial values.
REQ-025 abort outside SWEEP SHALL have no effect; if start and abort are both high in IDLE, start wins.
REQ-026 mismatch_cnt SHALL not saturate, since its width holds 2^NVARS exactly.

Reset
REQ-027 While rst_n = 0, asynchronously:
- state = IDLE;
- vec = 0 and the settle counter = 0;
- busy, done, pass, first_fail_valid = 0;
- mismatch_cnt = 0 and first_fail_vec = 0.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep; the block SHALL be in IDLE on the first edge after rst_n rises.

Structure
REQ-029 The FSM state encodings and the default NVARS/SETTLE values SHALL live in a shared package, tt_sweep_pkg, reused by benches.
REQ-030 The vector generator SHALL be one sub-module, tt_vec_counter (settle counter plus NVARS-bit vector counter with last-vector flag); all other logic SHALL be in truth_table_sweeper.
REQ-031 The functions under test SHALL stay outside this block; the bench wires vec to A..E and the chosen output pair to ref_out/cand_out.

Verification
REQ-032 Equal functions (cand_out = ref_out), NVARS=5, SETTLE=1:
- start at edge 0 -> done high in the cycle after edge 32;
- mismatch_cnt = 0, pass = 1, first_fail_valid = 0.
REQ-033 cand_out = ref_out XOR (vec == 13):
- mismatch_cnt = 1, first_fail_vec = 13, first_fail_valid = 1, pass = 0.
REQ-034 cand_out = ~ref_out:
- mismatch_cnt = 32, first_fail_vec = 0.
REQ-035 SETTLE=3 -> done after edge 96.
- A start pulse at edge 40 is ignored: no restart, and done still follows edge 96.
REQ-036 abort at edge 10 of a sweep, with mismatches injected at vec 3 and 7:
- busy = 0 at edge 11, no done, vec = 0;
- mismatch_cnt = 2, first_fail_vec = 3.
REQ-037 rst_n pulled low asynchronously at vec = 20:
- all outputs zero immediately;
- a new start after release completes a normal 32-vector sweep.
